tmr_vote_ctrl: RTL and testbench
================================

Name: tmr_vote_ctrl

Overview:
Sequencing controller for a bitwise 3-input majority voter used as a triple-modular-redundancy (TMR) combiner. It accepts one word per valid/ready transfer from three redundant channels and registers the bitwise majority. It tracks consecutive per-channel disagreements, declares channels faulted, and steps through RUN/DEGRADED/HALT modes. It sits between three replicated producers and a single downstream consumer.

Parameters:
W, 8, data width of each channel and of the result
FAULT_THRESH, 3, consecutive disagreeing votes before a channel is declared faulted (1..255)
CNT_W, 8, width of the per-channel consecutive-disagreement counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  three channel words present
in_ready  out  1  controller accepts a vote this cycle
ch_a  in  W  channel A word
ch_b  in  W  channel B word
ch_c  in  W  channel C word
out_valid  out  1  registered result available
out_ready  in  1  consumer accepts result
out_data  out  W  voted word
out_mismatch  out  1  at least one channel input disagreed with out_data on this vote
fault  out  3  sticky fault flags {C,B,A}
halted  out  1  controller in HALT
clear_faults  in  1  clears fault flags and counters, returns to RUN
vote_count  out  32  total accepted votes (feature-gated)
mismatch_count  out  32  total votes with out_mismatch=1 (feature-gated)

Behaviour:
- Reset (rst=1 at clock edge): state=RUN; out_valid=0, out_data=0, out_mismatch=0, fault=000, halted=0, counters=0.
- Transfer: accept when in_valid && in_ready. in_ready = (state!=HALT) && (!out_valid || out_ready).
- Latency: one cycle. out_data, out_mismatch, out_valid are registered on the accept edge.
- out_valid stays high and out_data stays stable until out_ready=1. Accept and drain in the same cycle yields full throughput.
- RUN (fault=000): out_data = (a&b)|(a&c)|(b&c), bitwise.
- DEGRADED (exactly one fault bit set): the faulted channel is ignored.
  - Healthy channels agree: out_data = that value, out_mismatch=0.
  - Healthy channels differ: out_data = lowest-lettered healthy channel, out_mismatch=1.
- Per accepted vote, for each non-faulted channel X:
  - if X != out_data_next, its counter increments (saturates at 2^CNT_W-1); otherwise the counter resets to 0.
  - When the counter reaches FAULT_THRESH, fault[X] sets on that same edge.
- In RUN, out_mismatch=1 when any channel differs from the majority.
- State transitions, evaluated on the accept edge using next-fault values:
  - RUN→DEGRADED when one fault is set.
  - RUN or DEGRADED→HALT when ≥2 faults are set. Two channels can reach threshold on the same vote, so RUN→HALT is direct.
- HALT: halted=1, in_ready=0. An out_valid already pending still drains normally.
- clear_faults=1 (any state, lower priority than rst): fault=000, all counters=0, state=RUN.
  - Any vote accepted in that same cycle is still output, but it does not update counters or faults.
- Faults are sticky; only clear_faults or rst clear them.

Optional Feature:
VOTE_STATS_EN
- Defined: vote_count increments on every accept. mismatch_count increments on every accept whose registered out_mismatch is 1. Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst or clear_faults.
- Undefined: both ports are driven constant 0 and no counter registers are inferred. The port list is unchanged.

Test Plan:
- Reset/basic vote: W=8; after rst, drive a=0x0F, b=0x33, c=0x55 with out_ready=1 → next cycle out_valid=1, out_data=0x17, out_mismatch=1, fault=000.
- Backpressure: out_ready=0, two votes offered → first captured, in_ready=0 on second cycle, out_data held; raise out_ready → second accepted in that cycle, no loss or duplication.
- Fault detection: a=b=0xAA, c=0x00 for 3 consecutive accepts (THRESH=3) → fault=100 after third edge, state DEGRADED. An intervening agreeing vote after 2 mismatches resets the count and no fault is raised.
- Degraded voting: fault=100, a=0x01, b=0x02 → out_data=0x01, out_mismatch=1. With a=b=0x7E → out_data=0x7E, out_mismatch=0.
- Halt and recovery: fault=100, then a≠b for 3 votes with a agreeing with its own prior output → B faults, halted=1, in_ready=0. Pulse clear_faults → fault=000, halted=0, in_ready=1.
- Stats (VOTE_STATS_EN): 10 votes with 4 mismatches → vote_count=10, mismatch_count=4. Synchronous rst mid-stream → all outputs and counters 0 on the next edge.

Source files
------------

// File: rtl/tmr_vote_ctrl_if.sv
// rtl/tmr_vote_ctrl_if.sv - Vote input and result output handshake bundle for tmr_vote_ctrl.
interface tmr_vote_ctrl_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ch_a;
    logic [W-1:0] ch_b;
    logic [W-1:0] ch_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mismatch;

    modport master (
        output in_valid, ch_a, ch_b, ch_c, out_ready,
        input  in_ready, out_valid, out_data, out_mismatch
    );

    modport slave (
        input  in_valid, ch_a, ch_b, ch_c, out_ready,
        output in_ready, out_valid, out_data, out_mismatch
    );
endinterface

// File: rtl/tmr_vote_ctrl.sv
// rtl/tmr_vote_ctrl.sv - TMR majority-vote sequencer with per-channel fault tracking and RUN/DEGRADED/HALT modes.
// Optional vote statistics counters are enabled by defining VOTE_STATS_EN.
module tmr_vote_ctrl #(
    parameter int W            = 8,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    tmr_vote_ctrl_if.slave    bus,
    input  logic              clear_faults,
    output logic [2:0]        fault,
    output logic              halted,
    output logic [31:0]       vote_count,
    output logic [31:0]       mismatch_count
);
    typedef enum logic [1:0] {ST_RUN, ST_DEGRADED, ST_HALT} state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FAULT_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                  state_q;
    logic                    halted_q;
    logic                    out_valid_q;
    logic [W-1:0]            out_data_q;
    logic                    out_mismatch_q;
    logic [2:0]              fault_q, fault_d;
    logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0][W-1:0]       ch;
    logic [W-1:0]            maj, h0, h1, vote_data;
    logic                    vote_mm;
    logic                    accept;
    logic [1:0]              n_faults_d;

    assign ch           = {bus.ch_c, bus.ch_b, bus.ch_a};
    assign bus.in_ready = (state_q != ST_HALT) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // With one channel faulted, vote between the two survivors and prefer the lower letter on a tie.
    always_comb begin
        maj       = (bus.ch_a & bus.ch_b) | (bus.ch_a & bus.ch_c) | (bus.ch_b & bus.ch_c);
        vote_data = maj;
        vote_mm   = (bus.ch_a != maj) || (bus.ch_b != maj) || (bus.ch_c != maj);
        h0        = bus.ch_a;
        h1        = bus.ch_b;
        case (fault_q)
            3'b001:  begin h0 = bus.ch_b; h1 = bus.ch_c; end
            3'b010:  begin h0 = bus.ch_a; h1 = bus.ch_c; end
            3'b100:  begin h0 = bus.ch_a; h1 = bus.ch_b; end
            default: ;
        endcase
        if ($onehot(fault_q)) begin
            vote_data = h0;
            vote_mm   = (h0 != h1);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (clear_faults) begin
            cnt_d   = '0;
            fault_d = 3'b000;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                if (!fault_q[i]) begin
                    if (ch[i] != vote_data) begin
                        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
                    end else begin
                        cnt_d[i] = '0;
                    end
                    if (cnt_d[i] >= THRESH_C) begin
                        fault_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign n_faults_d = 2'(fault_d[0]) + 2'(fault_d[1]) + 2'(fault_d[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            halted_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_mismatch_q <= 1'b0;
            fault_q        <= 3'b000;
            cnt_q          <= '0;
        end else begin
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                out_valid_q    <= 1'b1;
                out_data_q     <= vote_data;
                out_mismatch_q <= vote_mm;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (clear_faults) begin
                state_q  <= ST_RUN;
                halted_q <= 1'b0;
            end else if (accept) begin
                case (state_q)
                    ST_RUN: begin
                        if (n_faults_d >= 2'd2) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else if (n_faults_d == 2'd1) begin
                            state_q <= ST_DEGRADED;
                        end
                    end
                    ST_DEGRADED: begin
                        if (n_faults_d >= 2'd2) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_mismatch = out_mismatch_q;
    assign fault            = fault_q;
    assign halted           = halted_q;

`ifdef VOTE_STATS_EN
    logic [31:0] vote_cnt_q;
    logic [31:0] mism_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_faults) begin
            vote_cnt_q <= '0;
            mism_cnt_q <= '0;
        end else if (accept) begin
            if (vote_cnt_q != 32'hFFFF_FFFF) vote_cnt_q <= vote_cnt_q + 32'd1;
            if (vote_mm && (mism_cnt_q != 32'hFFFF_FFFF)) mism_cnt_q <= mism_cnt_q + 32'd1;
        end
    end

    assign vote_count     = vote_cnt_q;
    assign mismatch_count = mism_cnt_q;
`else
    assign vote_count     = 32'd0;
    assign mismatch_count = 32'd0;
`endif
endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// tb/tb_tmr_vote_ctrl.sv - Randomized and directed self-checking bench for tmr_vote_ctrl.
module tb_tmr_vote_ctrl;
    localparam int THRESH = 3;
`ifdef VOTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_faults;
    logic [2:0]  fault;
    logic        halted;
    logic [31:0] vote_count;
    logic [31:0] mismatch_count;
    int          checks   = 0;
    int          failures = 0;

    tmr_vote_ctrl_if #(.W(8)) bus ();

    tmr_vote_ctrl #(.W(8), .FAULT_THRESH(THRESH), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .clear_faults   (clear_faults),
        .fault          (fault),
        .halted         (halted),
        .vote_count     (vote_count),
        .mismatch_count (mismatch_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain counters and flags derived from the voting rules.
    int       m_cnt [3];
    bit       m_fault [3];
    bit       m_ov;
    bit [7:0] m_data;
    bit       m_mm;
    int       m_votes;
    int       m_mism;

    function automatic int nfaults();
        return int'(m_fault[0]) + int'(m_fault[1]) + int'(m_fault[2]);
    endfunction

    function automatic logic [2:0] exp_fault();
        return {m_fault[2], m_fault[1], m_fault[0]};
    endfunction

    function automatic logic [31:0] exp_vc();
        return STATS ? 32'(m_votes) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_mc();
        return STATS ? 32'(m_mism) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]   = 0;
            m_fault[i] = 1'b0;
        end
        m_ov = 0; m_data = 8'h00; m_mm = 0; m_votes = 0; m_mism = 0;
    endtask

    task automatic model_edge(input bit acc, input bit ordy, input bit clr,
                              input bit [7:0] a, input bit [7:0] b, input bit [7:0] c);
        bit [7:0] v [3];
        bit [7:0] d;
        bit       mm;
        int       h [$];
        v[0] = a; v[1] = b; v[2] = c;
        if (acc) begin
            if (nfaults() == 0) begin
                for (int k = 0; k < 8; k++) begin
                    d[k] = (int'(v[0][k]) + int'(v[1][k]) + int'(v[2][k])) >= 2;
                end
                mm = (v[0] != d) || (v[1] != d) || (v[2] != d);
            end else begin
                for (int i = 0; i < 3; i++) if (!m_fault[i]) h.push_back(i);
                d  = v[h[0]];
                mm = (v[h[0]] != v[h[1]]);
            end
            m_ov = 1; m_data = d; m_mm = mm;
            if (!clr) begin
                for (int i = 0; i < 3; i++) begin
                    if (!m_fault[i]) begin
                        m_cnt[i] = (v[i] != d) ? ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255) : 0;
                        if (m_cnt[i] >= THRESH) m_fault[i] = 1'b1;
                    end
                end
                m_votes++;
                if (mm) m_mism++;
            end
        end else if (ordy) begin
            m_ov = 0;
        end
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i]   = 0;
                m_fault[i] = 1'b0;
            end
            m_votes = 0; m_mism = 0;
        end
    endtask

    // One clock of stimulus; returns observed and model-predicted in_ready just before the edge.
    task automatic step(input bit iv, input bit [7:0] a, input bit [7:0] b, input bit [7:0] c,
                        input bit ordy, input bit clr, output bit got_rdy, output bit exp_rdy);
        bus.in_valid  = iv;
        bus.ch_a      = a;
        bus.ch_b      = b;
        bus.ch_c      = c;
        bus.out_ready = ordy;
        clear_faults  = clr;
        #3;
        got_rdy = bus.in_ready;
        exp_rdy = (nfaults() < 2) && (!m_ov || ordy);
        @(posedge clk);
        model_edge(iv && exp_rdy, ordy, clr, a, b, c);
        #1;
        bus.in_valid = 1'b0;
        clear_faults = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear_faults = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ch_a = 8'h00; bus.ch_b = 8'h00; bus.ch_c = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        if (bus.out_mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b exp=0", bus.out_mismatch); end
        if (fault !== 3'b000) begin failures++; $display("FAIL reset_fault got=%b exp=000", fault); end
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        if (vote_count !== 32'd0) begin failures++; $display("FAIL reset_vote_count got=%0d exp=0", vote_count); end
        if (mismatch_count !== 32'd0) begin failures++; $display("FAIL reset_mismatch_count got=%0d exp=0", mismatch_count); end
    endtask

    task automatic test_basic_vote();
        bit gr, er;
        do_reset();
        step(1, 8'h0F, 8'h33, 8'h55, 1, 0, gr, er);
        checks += 5;
        if (gr !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", gr); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== 8'h17 || bus.out_data !== m_data) begin failures++; $display("FAIL basic_out_data got=%h exp=17 model=%h", bus.out_data, m_data); end
        if (bus.out_mismatch !== 1'b1) begin failures++; $display("FAIL basic_mismatch got=%b exp=1", bus.out_mismatch); end
        if (fault !== 3'b000) begin failures++; $display("FAIL basic_fault got=%b exp=000", fault); end
    endtask

    task automatic test_backpressure();
        bit gr, er;
        do_reset();
        step(1, 8'h11, 8'h11, 8'h11, 0, 0, gr, er);
        step(1, 8'h22, 8'h22, 8'h22, 0, 0, gr, er);
        checks += 3;
        if (gr !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b exp=%b", gr, er); end
        if (bus.out_data !== 8'h11) begin failures++; $display("FAIL bp_held_data got=%h exp=11", bus.out_data); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_held_valid got=%b exp=1", bus.out_valid); end
        step(1, 8'h22, 8'h22, 8'h22, 1, 0, gr, er);
        checks += 3;
        if (gr !== 1'b1) begin failures++; $display("FAIL bp_in_ready_release got=%b exp=1", gr); end
        if (bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_vote got=%h/%b exp=22/1", bus.out_data, bus.out_valid); end
        if (vote_count !== exp_vc()) begin failures++; $display("FAIL bp_vote_count got=%0d exp=%0d", vote_count, exp_vc()); end
        step(0, 8'h00, 8'h00, 8'h00, 1, 0, gr, er);
        checks += 1;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_fault_detect();
        bit gr, er;
        bit [7:0] cv [6] = '{8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 8'hAA, 8'hAA, cv[i], 1, 0, gr, er);
            checks += 2;
            if (bus.out_data !== 8'hAA) begin failures++; $display("FAIL fault_vote_%0d got=%h exp=aa", i, bus.out_data); end
            if (fault !== exp_fault() || fault !== ((i == 5) ? 3'b100 : 3'b000)) begin
                failures++; $display("FAIL fault_flags_%0d got=%b model=%b", i, fault, exp_fault());
            end
        end
        checks += 2;
        if (halted !== 1'b0) begin failures++; $display("FAIL fault_not_halted got=%b exp=0", halted); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fault_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_degraded();
        bit gr, er;
        step(1, 8'h01, 8'h02, 8'hFF, 1, 0, gr, er);
        checks += 2;
        if (bus.out_data !== 8'h01 || bus.out_mismatch !== 1'b1) begin failures++; $display("FAIL degr_split got=%h/%b exp=01/1", bus.out_data, bus.out_mismatch); end
        if (fault !== 3'b100) begin failures++; $display("FAIL degr_fault got=%b exp=100", fault); end
        step(1, 8'h7E, 8'h7E, 8'h00, 1, 0, gr, er);
        checks += 1;
        if (bus.out_data !== 8'h7E || bus.out_mismatch !== 1'b0) begin failures++; $display("FAIL degr_agree got=%h/%b exp=7e/0", bus.out_data, bus.out_mismatch); end
    endtask

    task automatic test_halt_recovery();
        bit gr, er;
        for (int i = 0; i < 3; i++) step(1, 8'h11, 8'h22, 8'h33, 1, 0, gr, er);
        checks += 3;
        if (fault !== 3'b110 || fault !== exp_fault()) begin failures++; $display("FAIL halt_fault got=%b exp=110", fault); end
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        if (bus.out_data !== 8'h11) begin failures++; $display("FAIL halt_last_vote got=%h exp=11", bus.out_data); end
        step(1, 8'h44, 8'h44, 8'h44, 1, 0, gr, er);
        checks += 2;
        if (gr !== 1'b0) begin failures++; $display("FAIL halt_in_ready got=%b exp=0", gr); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL halt_drain got=%b exp=0", bus.out_valid); end
        step(0, 8'h00, 8'h00, 8'h00, 1, 1, gr, er);
        checks += 3;
        if (fault !== 3'b000) begin failures++; $display("FAIL clear_fault got=%b exp=000", fault); end
        if (halted !== 1'b0) begin failures++; $display("FAIL clear_halted got=%b exp=0", halted); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL clear_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_clear_with_vote();
        bit gr, er;
        do_reset();
        step(1, 8'hAA, 8'hAA, 8'h00, 1, 0, gr, er);
        step(1, 8'hAA, 8'hAA, 8'h00, 1, 0, gr, er);
        step(1, 8'hAA, 8'hAA, 8'h00, 1, 1, gr, er);
        checks += 2;
        if (bus.out_data !== 8'hAA || bus.out_mismatch !== 1'b1) begin failures++; $display("FAIL clrvote_output got=%h/%b exp=aa/1", bus.out_data, bus.out_mismatch); end
        if (fault !== 3'b000) begin failures++; $display("FAIL clrvote_fault got=%b exp=000", fault); end
        for (int i = 0; i < 3; i++) begin
            step(1, 8'hAA, 8'hAA, 8'h00, 1, 0, gr, er);
            checks += 1;
            if (fault !== ((i == 2) ? 3'b100 : 3'b000)) begin failures++; $display("FAIL clrvote_restart_%0d got=%b", i, fault); end
        end
    endtask

    task automatic test_random();
        bit gr, er;
        bit [7:0] base, v [3];
        do_reset();
        for (int n = 0; n < 500; n++) begin
            base = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                v[i] = base;
                if ($urandom_range(3, 0) == 0) v[i] = base ^ 8'($urandom_range(255, 1));
            end
            step($urandom_range(3, 0) != 0, v[0], v[1], v[2], $urandom_range(9, 0) < 7,
                 $urandom_range(39, 0) == 0, gr, er);
            checks += 5;
            if (gr !== er) begin failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, gr, er); end
            if (bus.out_valid !== m_ov) begin failures++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, bus.out_valid, m_ov); end
            if (m_ov && (bus.out_data !== m_data || bus.out_mismatch !== m_mm)) begin
                failures++; $display("FAIL rand_result n=%0d got=%h/%b exp=%h/%b", n, bus.out_data, bus.out_mismatch, m_data, m_mm);
            end
            if (fault !== exp_fault() || halted !== (nfaults() >= 2)) begin
                failures++; $display("FAIL rand_fault n=%0d got=%b/%b exp=%b/%b", n, fault, halted, exp_fault(), nfaults() >= 2);
            end
            if (vote_count !== exp_vc() || mismatch_count !== exp_mc()) begin
                failures++; $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, vote_count, mismatch_count, exp_vc(), exp_mc());
            end
        end
    endtask

    task automatic test_stats();
        bit gr, er;
        bit [7:0] sa [10] = '{8'h05, 8'h05, 8'h06, 8'h07, 8'h01, 8'h03, 8'h09, 8'h08, 8'h04, 8'h02};
        bit [7:0] sb [10] = '{8'h05, 8'h05, 8'h06, 8'h06, 8'h01, 8'h02, 8'h09, 8'h08, 8'h04, 8'h02};
        bit [7:0] sc [10] = '{8'h05, 8'h04, 8'h06, 8'h07, 8'h01, 8'h02, 8'h09, 8'h00, 8'h04, 8'h02};
        do_reset();
        for (int i = 0; i < 10; i++) step(1, sa[i], sb[i], sc[i], 1, 0, gr, er);
        checks += 2;
        if (vote_count !== (STATS ? 32'd10 : 32'd0) || vote_count !== exp_vc()) begin failures++; $display("FAIL stats_votes got=%0d exp=%0d", vote_count, exp_vc()); end
        if (mismatch_count !== (STATS ? 32'd4 : 32'd0) || mismatch_count !== exp_mc()) begin failures++; $display("FAIL stats_mismatch got=%0d exp=%0d", mismatch_count, exp_mc()); end
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.ch_a = 8'hF0; bus.ch_b = 8'h0F; bus.ch_c = 8'hFF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        model_reset();
        checks += 3;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_mismatch !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got=%b/%h/%b exp=0/00/0", bus.out_valid, bus.out_data, bus.out_mismatch);
        end
        if (fault !== 3'b000 || halted !== 1'b0) begin failures++; $display("FAIL midrst_status got=%b/%b exp=000/0", fault, halted); end
        if (vote_count !== 32'd0 || mismatch_count !== 32'd0) begin failures++; $display("FAIL midrst_stats got=%0d/%0d exp=0/0", vote_count, mismatch_count); end
    endtask

    initial begin
        test_reset();
        test_basic_vote();
        test_backpressure();
        test_fault_detect();
        test_degraded();
        test_halt_recovery();
        test_clear_with_vote();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
